// File: rtl/eros_cpu_obi_demux_pkg.sv
// eros_cpu_obi_demux_pkg: address-map rule type, private CPU map and demux constants.
package addr_map_rule_pkg;
    typedef struct packed {
        logic [31:0] idx;
        logic [31:0] start_addr;
        logic [31:0] end_addr;
    } addr_map_rule_t;
endpackage

package eros_pkg;
    import addr_map_rule_pkg::*;
    localparam int CPU_XBAR_SLAVE = 2;
    localparam int CPU_XBAR_NRULES = 3;
    localparam logic [31:0] ERR_RDATA = 32'hBADA_CCE5;
    typedef logic [$clog2(CPU_XBAR_SLAVE+1)-1:0] cpu_demux_tgt_t;
    // Rule 0 is the rightmost element: private CPU registers first, then system bus windows.
    localparam addr_map_rule_t [CPU_XBAR_NRULES-1:0] CPU_XBAR_ADDR_RULES = {
        addr_map_rule_t'{idx: 32'd0, start_addr: 32'h0000_0000, end_addr: 32'h4000_0000},
        addr_map_rule_t'{idx: 32'd0, start_addr: 32'hF001_0000, end_addr: 32'hFFFF_FFFF},
        addr_map_rule_t'{idx: 32'd1, start_addr: 32'hF000_0000, end_addr: 32'hF001_0000}
    };
endpackage

// File: rtl/eros_cpu_obi_demux_if.sv
// eros_cpu_obi_demux_if: core-side OBI data port plus the per-slave fan-out bundle.
interface eros_cpu_obi_demux_if #(
    parameter int NSLAVE = eros_pkg::CPU_XBAR_SLAVE
);
    logic                   req_i, we_i;
    logic [31:0]            addr_i, wdata_i;
    logic [3:0]             be_i;
    logic                   gnt_o, rvalid_o, err_o;
    logic [31:0]            rdata_o;
    logic [NSLAVE-1:0]      slv_req_o, slv_we_o;
    logic [NSLAVE-1:0][31:0] slv_addr_o, slv_wdata_o;
    logic [NSLAVE-1:0][3:0] slv_be_o;
    logic [NSLAVE-1:0]      slv_gnt_i, slv_rvalid_i;
    logic [NSLAVE-1:0][31:0] slv_rdata_i;

    modport slave (
        input  req_i, we_i, addr_i, wdata_i, be_i, slv_gnt_i, slv_rvalid_i, slv_rdata_i,
        output gnt_o, rvalid_o, err_o, rdata_o, slv_req_o, slv_we_o, slv_addr_o, slv_wdata_o, slv_be_o
    );
    modport master (
        output req_i, we_i, addr_i, wdata_i, be_i, slv_gnt_i, slv_rvalid_i, slv_rdata_i,
        input  gnt_o, rvalid_o, err_o, rdata_o, slv_req_o, slv_we_o, slv_addr_o, slv_wdata_o, slv_be_o
    );
endinterface

// File: rtl/eros_addr_decode.sv
// eros_addr_decode: combinational address-map matcher; lowest matching rule index wins.
module eros_addr_decode
    import addr_map_rule_pkg::*;
#(
    parameter int NRULES = eros_pkg::CPU_XBAR_NRULES,
    parameter int IW = 2,
    parameter addr_map_rule_t [NRULES-1:0] ADDR_RULES = eros_pkg::CPU_XBAR_ADDR_RULES
) (
    input  logic [31:0]   addr,
    output logic [IW-1:0] idx,
    output logic          match
);
    always_comb begin
        idx = '0;
        match = 1'b0;
        for (int i = NRULES - 1; i >= 0; i--)
            if (addr >= ADDR_RULES[i].start_addr && addr < ADDR_RULES[i].end_addr) begin
                idx = ADDR_RULES[i].idx[IW-1:0];
                match = 1'b1;
            end
    end
endmodule

// File: rtl/eros_cpu_obi_demux.sv
// eros_cpu_obi_demux: per-core OBI demux over the private CPU map with in-order
// response tracking and an internal error responder for unmapped addresses.
module eros_cpu_obi_demux
    import addr_map_rule_pkg::*;
    import eros_pkg::*;
#(
    parameter int NSLAVE = CPU_XBAR_SLAVE,
    parameter int NRULES = CPU_XBAR_NRULES,
    parameter addr_map_rule_t [NRULES-1:0] ADDR_RULES = CPU_XBAR_ADDR_RULES,
    parameter int MAX_OUTSTANDING = 2
) (
    input logic clk_i,
    input logic rst_i,
    eros_cpu_obi_demux_if.slave bus
);
    localparam int TW = $clog2(NSLAVE + 1);
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [TW-1:0] ERR = TW'(NSLAVE);

    logic [TW-1:0] idx, dec, tgt_q;
    logic [CW-1:0] cnt_q;
    logic          match, go, dec_err, tgt_err, err_pend_q, sel_gnt, sel_rvalid;
    logic [31:0]   sel_rdata;

    eros_addr_decode #(.NRULES(NRULES), .IW(TW), .ADDR_RULES(ADDR_RULES)) u_decode (
        .addr(bus.addr_i),
        .idx(idx),
        .match(match)
    );

    assign dec = match ? idx : ERR;
    assign dec_err = dec == ERR;
    assign tgt_err = tgt_q == ERR;
    // Switching target only once everything is answered keeps responses in order.
    assign go = bus.req_i && (cnt_q == '0 || dec == tgt_q) && cnt_q < CW'(MAX_OUTSTANDING);

    always_comb begin
        sel_gnt = 1'b0;
        sel_rvalid = 1'b0;
        sel_rdata = bus.slv_rdata_i[0];
        bus.slv_req_o = '0;
        for (int i = 0; i < NSLAVE; i++) begin
            bus.slv_req_o[i] = go && dec == TW'(i);
            if (dec == TW'(i)) sel_gnt = bus.slv_gnt_i[i];
            if (tgt_q == TW'(i)) begin
                sel_rvalid = bus.slv_rvalid_i[i];
                sel_rdata = bus.slv_rdata_i[i];
            end
        end
    end

    assign bus.slv_we_o = {NSLAVE{bus.we_i}};
    assign bus.slv_addr_o = {NSLAVE{bus.addr_i}};
    assign bus.slv_wdata_o = {NSLAVE{bus.wdata_i}};
    assign bus.slv_be_o = {NSLAVE{bus.be_i}};
    assign bus.gnt_o = go && (dec_err || sel_gnt);
    // Responses with nothing outstanding (e.g. after a reset) are dropped here.
    assign bus.rvalid_o = tgt_err ? err_pend_q : sel_rvalid && cnt_q != '0;
    assign bus.err_o = tgt_err && err_pend_q;
    assign bus.rdata_o = tgt_err ? ERR_RDATA : sel_rdata;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            tgt_q <= '0;
            err_pend_q <= 1'b0;
        end else begin
            cnt_q <= cnt_q + CW'(bus.gnt_o) - CW'(bus.rvalid_o);
            if (bus.gnt_o) tgt_q <= dec;
            err_pend_q <= (bus.gnt_o && dec_err) || (err_pend_q && !bus.rvalid_o);
        end
    end
endmodule
